// File: rtl/depth_frame_streamer_pkg.sv
// Shared RGB-D VO configuration constants used by the depth streaming path.
package RgbdVoConfigPk;
  localparam int DATA_DEPTH_BW = 16;
  localparam int H_SIZE_BW     = 10;
  localparam int V_SIZE_BW     = 10;
  localparam int FRAME_ADDR_BW = 24;
endpackage

// File: rtl/depth_frame_streamer_fifo.sv
// Response buffer between the read-return port and the pixel output stage.
// Read data is combinational from the head entry; an extra pointer bit
// separates full from empty.
module depth_stream_fifo
  import RgbdVoConfigPk::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_DEPTH_BW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[PW-1:0]];

  // Pointer update; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end
endmodule

// File: rtl/depth_frame_streamer.sv
// Fetches one depth frame with credit-limited in-order reads and emits it as
// a raster pixel stream framed by start/end pulses.
// state | meaning
// IDLE  | waiting for i_start
// SOF   | one cycle, launches frame_start and first request
// RUN   | issuing reads, draining response buffer into pixels
// EOF   | one cycle, launches frame_end
module depth_frame_streamer
  import RgbdVoConfigPk::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_BW    = FRAME_ADDR_BW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [H_SIZE_BW-1:0]     r_hsize,
  input  logic [V_SIZE_BW-1:0]     r_vsize,
  input  logic [ADDR_BW-1:0]       r_base_addr,
  output logic                     o_rd_req,
  output logic [ADDR_BW-1:0]       o_rd_addr,
  input  logic                     i_rd_gnt,
  input  logic                     i_rd_valid,
  input  logic [DATA_DEPTH_BW-1:0] i_rd_data,
  output logic                     o_frame_start,
  output logic                     o_frame_end,
  output logic                     o_valid,
  output logic [DATA_DEPTH_BW-1:0] o_depth,
  output logic [H_SIZE_BW-1:0]     o_idx_x,
  output logic [V_SIZE_BW-1:0]     o_idx_y,
  output logic                     o_busy,
  output logic                     o_err
);
  localparam int TOT_BW = H_SIZE_BW + V_SIZE_BW;
  localparam int CNT_BW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_BW-1:0] DEPTH_CNT = CNT_BW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SOF, RUN, EOF} state_t;

  state_t                   state, state_n;
  logic [H_SIZE_BW-1:0]     hsize, hsize_n, x, x_n;
  logic [V_SIZE_BW-1:0]     vsize, vsize_n, y, y_n;
  logic [ADDR_BW-1:0]       base, base_n;
  logic [TOT_BW-1:0]        total, total_n, req_cnt, req_cnt_n, pop_cnt, pop_cnt_n;
  logic [CNT_BW-1:0]        inflight, inflight_n;
  logic                     rd_req, rd_req_n;
  logic [ADDR_BW-1:0]       rd_addr, rd_addr_n;
  logic                     frame_start, frame_start_n, frame_end, frame_end_n;
  logic                     valid, valid_n, busy, busy_n, err, err_n;
  logic [DATA_DEPTH_BW-1:0] depth, depth_n;
  logic [H_SIZE_BW-1:0]     idx_x, idx_x_n;
  logic [V_SIZE_BW-1:0]     idx_y, idx_y_n;

  logic                     gnt_fire, stray, push, pop;
  logic                     fifo_empty, fifo_full;
  logic [DATA_DEPTH_BW-1:0] fifo_rdata;

  // A return with no credit outstanding cannot belong to this frame.
  assign gnt_fire = rd_req & i_rd_gnt;
  assign stray    = i_rd_valid & (inflight == '0);
  assign push     = i_rd_valid & ~stray & ~fifo_full;
  assign pop      = (state == RUN) & ~fifo_empty;

  depth_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_DEPTH_BW)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata (i_rd_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_n       = state;
    hsize_n       = hsize;
    vsize_n       = vsize;
    base_n        = base;
    total_n       = total;
    x_n           = x;
    y_n           = y;
    req_cnt_n     = req_cnt + TOT_BW'(gnt_fire);
    pop_cnt_n     = pop_cnt;
    inflight_n    = inflight + CNT_BW'(gnt_fire) - CNT_BW'(pop);
    rd_req_n      = rd_req;
    rd_addr_n     = rd_addr;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    valid_n       = 1'b0;
    depth_n       = depth;
    idx_x_n       = idx_x;
    idx_y_n       = idx_y;
    err_n         = err | stray;
    case (state)
      IDLE: begin
        if (i_start) begin
          hsize_n    = r_hsize;
          vsize_n    = r_vsize;
          base_n     = r_base_addr;
          req_cnt_n  = '0;
          pop_cnt_n  = '0;
          inflight_n = '0;
          x_n        = '0;
          y_n        = '0;
          err_n      = 1'b0;
          state_n    = SOF;
        end
      end
      SOF: begin
        frame_start_n = 1'b1;
        total_n       = TOT_BW'(hsize) * TOT_BW'(vsize);
        if (hsize == '0 || vsize == '0) begin
          state_n = EOF;
        end else begin
          rd_req_n  = 1'b1;
          rd_addr_n = base;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (pop) begin
          valid_n   = 1'b1;
          depth_n   = fifo_rdata;
          idx_x_n   = x;
          idx_y_n   = y;
          pop_cnt_n = pop_cnt + TOT_BW'(1);
          if (x == hsize - H_SIZE_BW'(1)) begin
            x_n = '0;
            y_n = y + V_SIZE_BW'(1);
          end else begin
            x_n = x + H_SIZE_BW'(1);
          end
          if (pop_cnt_n == total) state_n = EOF;
        end
        rd_req_n  = (req_cnt_n < total) && (inflight_n < DEPTH_CNT);
        rd_addr_n = base + ADDR_BW'(req_cnt_n);
      end
      EOF: begin
        frame_end_n = 1'b1;
        rd_req_n    = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) || frame_end_n;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      hsize       <= '0;
      vsize       <= '0;
      base        <= '0;
      total       <= '0;
      x           <= '0;
      y           <= '0;
      req_cnt     <= '0;
      pop_cnt     <= '0;
      inflight    <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      valid       <= 1'b0;
      depth       <= '0;
      idx_x       <= '0;
      idx_y       <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      hsize       <= hsize_n;
      vsize       <= vsize_n;
      base        <= base_n;
      total       <= total_n;
      x           <= x_n;
      y           <= y_n;
      req_cnt     <= req_cnt_n;
      pop_cnt     <= pop_cnt_n;
      inflight    <= inflight_n;
      rd_req      <= rd_req_n;
      rd_addr     <= rd_addr_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      valid       <= valid_n;
      depth       <= depth_n;
      idx_x       <= idx_x_n;
      idx_y       <= idx_y_n;
      busy        <= busy_n;
      err         <= err_n;
    end
  end

  assign o_rd_req      = rd_req;
  assign o_rd_addr     = rd_addr;
  assign o_frame_start = frame_start;
  assign o_frame_end   = frame_end;
  assign o_valid       = valid;
  assign o_depth       = depth;
  assign o_idx_x       = idx_x;
  assign o_idx_y       = idx_y;
  assign o_busy        = busy;
  assign o_err         = err;
endmodule

// File: doc/depth_frame_streamer.md
# depth_frame_streamer

Fetches one depth frame from external frame memory with a credit-limited, in-order read-request interface. Emits the frame as a raster pixel stream (frame_start / valid / depth / x,y / frame_end), the format the line-buffer write port consumes on its frame-1 input. It is the producer end of that stream and sits between the memory arbiter and the line-buffer controller.

## Interface
- FIFO_DEPTH, 8: response buffer entries and maximum in-flight reads; power of two, ≥2.
- ADDR_BW, 24: word address width of frame memory.
- i_clk  in  1  sole clock.
- i_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_start  in  1  one-cycle pulse; begins a frame when idle.
- r_hsize  in  H_SIZE_BW  pixels per line; sampled at accepted i_start.
- r_vsize  in  V_SIZE_BW  lines per frame; sampled at accepted i_start.
- r_base_addr  in  ADDR_BW  word address of pixel (0,0); sampled at accepted i_start.
- o_rd_req  out  1  read request.
- o_rd_addr  out  ADDR_BW  request address.
- i_rd_gnt  in  1  request accepted this cycle when o_rd_req=1.
- i_rd_valid  in  1  read data returning, in request order.
- i_rd_data  in  DATA_DEPTH_BW  returned depth word.
- o_frame_start  out  1  one-cycle pulse before first pixel.
- o_frame_end  out  1  one-cycle pulse after last pixel.
- o_valid  out  1  pixel valid.
- o_depth  out  DATA_DEPTH_BW  pixel depth, unmodified.
- o_idx_x  out  H_SIZE_BW  pixel column.
- o_idx_y  out  V_SIZE_BW  pixel row.
- o_busy  out  1  high from accepted i_start through the o_frame_end cycle.
- o_err  out  1  sticky: i_rd_valid arrived with zero reads in flight; cleared by reset or accepted i_start.

## Operation
- FSM states: IDLE, SOF, RUN, EOF.
- IDLE: i_start latches sizes/base, clears counters and o_err, goes to SOF. i_start in any other state is ignored.
- SOF: one cycle; registers o_frame_start=1 for the next cycle. Goes to EOF if hsize==0 or vsize==0 (no requests issued), else RUN.
- RUN, requests:
  - o_rd_req=1 while req_cnt < total and inflight < FIFO_DEPTH.
  - total = hsize*vsize at width H_SIZE_BW+V_SIZE_BW.
  - inflight = granted − popped.
  - o_rd_addr = base + req_cnt, wraps modulo 2^ADDR_BW.
  - On req&gnt: req_cnt+1 and inflight+1.
  - o_rd_req/o_rd_addr are registered and held stable until granted.
- RUN, responses: i_rd_valid writes i_rd_data into the FIFO. By construction of credits the FIFO never overflows; i_rd_valid with inflight==0 is dropped and sets o_err.
- RUN, pixels:
  - Each cycle the FIFO is non-empty, pop one entry and drive o_valid=1 next cycle with o_depth, o_idx_x, o_idx_y. inflight−1 on pop.
  - x increments per pixel and wraps to 0 at hsize−1, incrementing y.
  - When pixel total has been popped, go to EOF.
- Output gaps (o_valid=0 mid-frame) are legal and occur only when the FIFO is empty. No downstream back-pressure exists.
- EOF: o_frame_end=1 in the cycle after the last o_valid (or the cycle after o_frame_start for an empty frame), then IDLE.

## Timing
- Reset values:
  - o_rd_req, o_frame_start, o_frame_end, o_valid, o_busy, o_err = 0.
  - o_rd_addr, o_depth, o_idx_x, o_idx_y = 0.
  - FSM=IDLE; FIFO empty; all counters 0.
- i_start at cycle t:
  - o_busy=1 at t+1.
  - o_frame_start=1 at t+2.
  - First o_rd_req at t+2.
- i_rd_valid at cycle r: FIFO entry is visible at r+1 and popped at r+1 (if it is the head); o_valid at r+2. Pipeline latency is 2 cycles.
- o_frame_start and the first o_valid are never in the same cycle. o_frame_end is never in the same cycle as o_valid.
- Simultaneous FIFO push and pop in the same cycle is supported; occupancy is unchanged.
- Reset mid-frame returns everything to reset values immediately. Late returns after reset set o_err (documented behaviour).

## Structure
- Shared package RgbdVoConfigPk supplies DATA_DEPTH_BW, H_SIZE_BW, V_SIZE_BW and a new FRAME_ADDR_BW constant used as the ADDR_BW default. The FSM state enum stays local to the module.
- One sub-module: depth_stream_fifo, a synchronous FIFO (FIFO_DEPTH × DATA_DEPTH_BW) with push, pop, empty, full, and sync active-high reset.

## Test plan
- hsize=4, vsize=2, base=0x100, gnt always 1, read latency 3: addresses 0x100..0x107 issued in order; 8 o_valid with (x,y) (0,0)…(3,1) and depth matching memory; o_frame_start before and o_frame_end after.
- Latency 20, FIFO_DEPTH=8: never more than 8 requests ungranted-response; o_rd_req drops at 8 in flight and resumes the cycle after a pop.
- gnt toggled randomly with a held request: o_rd_addr stable while o_rd_req=1 and gnt=0; no address skipped or duplicated.
- hsize=0: o_frame_start, then o_frame_end the next cycle; no o_rd_req; o_busy low afterwards.
- Base=0xFFFFFE with 4 pixels: addresses FFFFFE, FFFFFF, 000000, 000001.
- i_rst asserted mid-frame, then stray i_rd_valid: all outputs 0 the following cycle, o_err=1 after the stray return; next i_start clears o_err and the frame completes normally.
